// File: rtl/regfile_pair_idu.sv
// Uniform bank of NPAIRS byte-addressable register pairs with a two-stage
// increment/decrement unit. The unit drives the address bus with the pre-op
// value and optionally writes the result back to its source pair.
module regfile_pair_idu #(
  parameter int              DW      = 8,
  parameter int              NPAIRS  = 4,
  parameter int              PAW     = 2,
  parameter int              BYPASS  = 1,
  parameter logic [2*DW-1:0] RST_VAL = '0
) (
  input  logic            CLK,
  input  logic            SYNC_RES,
  input  logic [PAW:0]    rd_a_sel,
  output logic [DW-1:0]   rd_a,
  input  logic [PAW:0]    rd_b_sel,
  output logic [DW-1:0]   rd_b,
  input  logic            wr8_en,
  input  logic [PAW:0]    wr8_sel,
  input  logic [DW-1:0]   wr8_d,
  input  logic            wr16_en,
  input  logic [PAW-1:0]  wr16_sel,
  input  logic [2*DW-1:0] wr16_d,
  input  logic            idu_req,
  input  logic [PAW-1:0]  idu_sel,
  input  logic [1:0]      idu_op,
  input  logic            idu_wb,
  output logic [2*DW-1:0] addr,
  output logic            addr_valid,
  output logic            idu_wrap
);

  localparam int AW    = 2 * DW;
  localparam int NSLOT = 1 << PAW;
  localparam logic [AW-1:0] ONE = AW'(1);

  // Pair storage and the single in-flight IDU stage (S1).
  logic [AW-1:0]  pair_reg [NPAIRS];
  logic [AW-1:0]  addr_reg;
  logic           addr_valid_reg;
  logic           idu_wrap_reg;
  logic           s1_valid_reg;
  logic           s1_wb_reg;
  logic [PAW-1:0] s1_sel_reg;
  logic [1:0]     s1_op_reg;

  // Merged next value per pair; also what bypassed reads observe.
  logic [AW-1:0]  pair_next [NPAIRS];
  // Padded views so out-of-range selects resolve to zero without range faults.
  logic [AW-1:0]  read_view [NSLOT];
  logic [AW-1:0]  src_view  [NSLOT];

  logic [AW-1:0]  s1_res;
  logic           s1_wb_act;
  logic [AW-1:0]  src;
  logic           wrap_next;

  // S1 result: addr_reg still holds the source value captured at the request.
  always_comb begin
    s1_res = addr_reg;
    case (s1_op_reg)
      2'b01:   s1_res = addr_reg + ONE;
      2'b10:   s1_res = addr_reg - ONE;
      default: s1_res = addr_reg;
    endcase
  end

  // A writeback only counts when it targets a real pair and reset is not active.
  assign s1_wb_act = s1_valid_reg && s1_wb_reg && !SYNC_RES && (int'(s1_sel_reg) < NPAIRS);

  // Per-byte merge: wr16 beats the IDU writeback, which beats wr8.
  always_comb begin
    for (int i = 0; i < NPAIRS; i++) begin
      logic hit16, hit_idu, hit8_hi, hit8_lo;
      hit16   = wr16_en && !SYNC_RES && (wr16_sel == PAW'(i));
      hit_idu = s1_wb_act && (s1_sel_reg == PAW'(i));
      hit8_hi = wr8_en && !SYNC_RES && (wr8_sel[PAW:1] == PAW'(i)) && wr8_sel[0];
      hit8_lo = wr8_en && !SYNC_RES && (wr8_sel[PAW:1] == PAW'(i)) && !wr8_sel[0];
      pair_next[i] = pair_reg[i];
      if (hit16)
        pair_next[i] = wr16_d;
      else if (hit_idu)
        pair_next[i] = s1_res;
      else begin
        if (hit8_hi) pair_next[i][AW-1:DW] = wr8_d;
        if (hit8_lo) pair_next[i][DW-1:0]  = wr8_d;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_view
      if (gi < NPAIRS) begin : g_real
        if (BYPASS != 0) begin : g_fwd
          assign read_view[gi] = pair_next[gi];
        end else begin : g_store
          assign read_view[gi] = pair_reg[gi];
        end
        assign src_view[gi] = pair_reg[gi];
      end else begin : g_pad
        assign read_view[gi] = '0;
        assign src_view[gi]  = '0;
      end
    end
  endgenerate

  assign rd_a = rd_a_sel[0] ? read_view[rd_a_sel[PAW:1]][AW-1:DW] : read_view[rd_a_sel[PAW:1]][DW-1:0];
  assign rd_b = rd_b_sel[0] ? read_view[rd_b_sel[PAW:1]][AW-1:DW] : read_view[rd_b_sel[PAW:1]][DW-1:0];

  // S0 source: forward the S1 result for back-to-back ops on the same pair.
  always_comb begin
    src = src_view[idu_sel];
    if (s1_wb_act && (s1_sel_reg == idu_sel))
      src = s1_res;
    wrap_next = ((idu_op == 2'b01) && (src == '1)) || ((idu_op == 2'b10) && (src == '0));
  end

  // Pair storage update; reset overrides every write source.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NPAIRS; i++) begin
      if (SYNC_RES) pair_reg[i] <= RST_VAL;
      else          pair_reg[i] <= pair_next[i];
    end
  end

  // IDU pipeline: capture source on request, otherwise hold addr and go idle.
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      addr_reg       <= '0;
      addr_valid_reg <= 1'b0;
      idu_wrap_reg   <= 1'b0;
      s1_valid_reg   <= 1'b0;
      s1_wb_reg      <= 1'b0;
      s1_sel_reg     <= '0;
      s1_op_reg      <= 2'b00;
    end else if (idu_req) begin
      addr_reg       <= src;
      addr_valid_reg <= 1'b1;
      idu_wrap_reg   <= wrap_next;
      s1_valid_reg   <= 1'b1;
      s1_wb_reg      <= idu_wb && (idu_op != 2'b11);
      s1_sel_reg     <= idu_sel;
      s1_op_reg      <= idu_op;
    end else begin
      addr_valid_reg <= 1'b0;
      idu_wrap_reg   <= 1'b0;
      s1_valid_reg   <= 1'b0;
      s1_wb_reg      <= 1'b0;
    end
  end

  assign addr       = addr_reg;
  assign addr_valid = addr_valid_reg;
  assign idu_wrap   = idu_wrap_reg;

endmodule

// File: tb/tb_regfile_pair_idu.sv
// Directed bench for regfile_pair_idu: a full-size bypassing instance and a
// three-pair non-bypassing instance share one stimulus stream.
module tb_regfile_pair_idu;

  logic        CLK = 1'b0;
  logic        SYNC_RES;
  logic [2:0]  rd_a_sel, rd_b_sel, wr8_sel;
  logic        wr8_en, wr16_en, idu_req, idu_wb;
  logic [7:0]  wr8_d;
  logic [1:0]  wr16_sel, idu_sel, idu_op;
  logic [15:0] wr16_d;

  logic [7:0]  rd_a, rd_b, rd_a_n, rd_b_n;
  logic [15:0] addr, addr_n;
  logic        addr_valid, idu_wrap, addr_valid_n, idu_wrap_n;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic        req_at_edge;
  logic [15:0] v, vn;

  always #5 CLK = ~CLK;

  regfile_pair_idu #(.DW(8), .NPAIRS(4), .PAW(2), .BYPASS(1), .RST_VAL(16'h0000)) dut (
    .CLK(CLK), .SYNC_RES(SYNC_RES),
    .rd_a_sel(rd_a_sel), .rd_a(rd_a), .rd_b_sel(rd_b_sel), .rd_b(rd_b),
    .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_d(wr8_d),
    .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_d(wr16_d),
    .idu_req(idu_req), .idu_sel(idu_sel), .idu_op(idu_op), .idu_wb(idu_wb),
    .addr(addr), .addr_valid(addr_valid), .idu_wrap(idu_wrap)
  );

  regfile_pair_idu #(.DW(8), .NPAIRS(3), .PAW(2), .BYPASS(0), .RST_VAL(16'h0000)) dut_n (
    .CLK(CLK), .SYNC_RES(SYNC_RES),
    .rd_a_sel(rd_a_sel), .rd_a(rd_a_n), .rd_b_sel(rd_b_sel), .rd_b(rd_b_n),
    .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_d(wr8_d),
    .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_d(wr16_d),
    .idu_req(idu_req), .idu_sel(idu_sel), .idu_op(idu_op), .idu_wb(idu_wb),
    .addr(addr_n), .addr_valid(addr_valid_n), .idu_wrap(idu_wrap_n)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr8_en = 1'b0; wr16_en = 1'b0; idu_req = 1'b0; idu_wb = 1'b0; idu_op = 2'b00;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [1:0] op, input logic wb,
                       input logic [15:0] exp_addr, input logic exp_wrap);
    idu_req = 1'b1; idu_sel = sel; idu_op = op; idu_wb = wb;
    exp_q.push_back({exp_addr, exp_wrap});
  endtask

  // Advance one edge; an IDU request at that edge is scored against the queue.
  task automatic step();
    logic [16:0] e;
    req_at_edge = idu_req;
    @(posedge CLK);
    #1;
    if (req_at_edge) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e = exp_q.pop_front();
        $display("idu txn: addr=%h wrap=%b valid=%b (expect addr=%h wrap=%b)",
                 addr, idu_wrap, addr_valid, e[16:1], e[0]);
        check("addr_valid", 16'(addr_valid), 16'd1);
        check("addr", addr, e[16:1]);
        check("idu_wrap", 16'(idu_wrap), 16'(e[0]));
      end
    end
  endtask

  task automatic read_pair(input logic [1:0] p, output logic [15:0] val, output logic [15:0] val_n);
    rd_a_sel = {p, 1'b1};
    rd_b_sel = {p, 1'b0};
    #1;
    val   = {rd_a, rd_b};
    val_n = {rd_a_n, rd_b_n};
    $display("read pair%0d: wide=%h narrow=%h", p, val, val_n);
  endtask

  initial begin
    idle();
    SYNC_RES = 1'b1;
    rd_a_sel = '0; rd_b_sel = '0; wr8_sel = '0; wr8_d = '0;
    wr16_sel = '0; wr16_d = '0; idu_sel = '0;

    // Reset
    step(); step();
    SYNC_RES = 1'b0;
    check("rst_addr", addr, 16'h0000);
    check("rst_addr_valid", 16'(addr_valid), 16'd0);
    check("rst_wrap", 16'(idu_wrap), 16'd0);
    for (int p = 0; p < 4; p++) begin
      read_pair(2'(p), v, vn);
      check("rst_pair", v, 16'h0000);
      if (p < 3) check("rst_pair_n", vn, 16'h0000);
    end

    // Back-to-back increment through the wrap point
    wr16_en = 1'b1; wr16_sel = 2'd1; wr16_d = 16'hFFFE;
    step(); idle();
    issue(2'd1, 2'b01, 1'b1, 16'hFFFE, 1'b0); step();
    issue(2'd1, 2'b01, 1'b1, 16'hFFFF, 1'b1); step();
    issue(2'd1, 2'b01, 1'b1, 16'h0000, 1'b0); step();
    idle(); step();
    check("b2b_valid_drop", 16'(addr_valid), 16'd0);
    read_pair(2'd1, v, vn);
    check("b2b_pair1", v, 16'h0001);
    check("b2b_pair1_n", vn, 16'h0001);

    // Priority: wr16 beats IDU writeback
    wr16_en = 1'b1; wr16_sel = 2'd2; wr16_d = 16'h1234;
    step(); idle();
    issue(2'd2, 2'b10, 1'b1, 16'h1234, 1'b0); step();
    idle(); wr16_en = 1'b1; wr16_sel = 2'd2; wr16_d = 16'hABCD;
    step(); idle();
    read_pair(2'd2, v, vn);
    check("prio_wr16", v, 16'hABCD);

    // Priority: IDU writeback beats wr8 on the same pair
    wr16_en = 1'b1; wr16_sel = 2'd2; wr16_d = 16'h1234;
    step(); idle();
    issue(2'd2, 2'b10, 1'b1, 16'h1234, 1'b0); step();
    idle(); wr8_en = 1'b1; wr8_sel = {2'd2, 1'b1}; wr8_d = 8'h55;
    read_pair(2'd2, v, vn);
    check("prio_fwd_bypass", v, 16'h1233);
    check("prio_fwd_nobypass", vn, 16'h1234);
    step(); idle();
    read_pair(2'd2, v, vn);
    check("prio_idu_over_wr8", v, 16'h1233);
    check("prio_idu_over_wr8_n", vn, 16'h1233);

    // Same-cycle read bypass vs stored read
    wr8_en = 1'b1; wr8_sel = {2'd0, 1'b0}; wr8_d = 8'h5A;
    rd_a_sel = {2'd0, 1'b0};
    #1;
    check("byp_same_cycle", 16'(rd_a), 16'h005A);
    check("nobyp_same_cycle", 16'(rd_a_n), 16'h0000);
    step(); idle();
    rd_a_sel = {2'd0, 1'b0};
    #1;
    check("byp_next_cycle", 16'(rd_a), 16'h005A);
    check("nobyp_next_cycle", 16'(rd_a_n), 16'h005A);

    // Reset while a writeback is in flight
    wr16_en = 1'b1; wr16_sel = 2'd3; wr16_d = 16'h0010;
    step(); idle();
    issue(2'd3, 2'b01, 1'b1, 16'h0010, 1'b0); step();
    idle(); SYNC_RES = 1'b1;
    step();
    SYNC_RES = 1'b0;
    check("midrst_addr_valid", 16'(addr_valid), 16'd0);
    check("midrst_addr", addr, 16'h0000);
    read_pair(2'd3, v, vn);
    check("midrst_pair3", v, 16'h0000);
    step();
    read_pair(2'd3, v, vn);
    check("midrst_pair3_later", v, 16'h0000);

    // Op 11 suppresses writeback
    wr16_en = 1'b1; wr16_sel = 2'd0; wr16_d = 16'h00FF;
    step(); idle();
    issue(2'd0, 2'b11, 1'b1, 16'h00FF, 1'b0); step();
    idle(); step();
    read_pair(2'd0, v, vn);
    check("op11_pair0", v, 16'h00FF);
    check("op11_pair0_n", vn, 16'h00FF);

    // Out-of-range IDU select on the three-pair instance
    issue(2'd3, 2'b01, 1'b1, 16'h0000, 1'b0); step();
    check("oor_addr_n", addr_n, 16'h0000);
    check("oor_valid_n", 16'(addr_valid_n), 16'd1);
    check("oor_wrap_n", 16'(idu_wrap_n), 16'd0);
    idle(); step();
    read_pair(2'd0, v, vn);
    check("oor_pair0_n", vn, 16'h00FF);
    read_pair(2'd1, v, vn);
    check("oor_pair1_n", vn, 16'h0000);
    read_pair(2'd2, v, vn);
    check("oor_pair2_n", vn, 16'h0000);
    read_pair(2'd3, v, vn);
    check("oor_pair3_wide", v, 16'h0001);
    check("oor_read_n", vn, 16'h0000);

    check("sb_drain", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
